// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: arbitrates the single register-file write port between
// the pipeline writeback (WB) and a DEPTH-entry FIFO of multi-cycle-unit
// (MDU) results. WB normally wins. When the FIFO has lost the port for
// STARVE_LIMIT consecutive cycles, stall_req is raised and the FIFO drains
// with priority until it is empty.
//
// Ports:
//   clk, rst                      clock, async active-high reset
//   wb_write/wb_add/wb_data       writeback write request
//   mdu_valid/mdu_add/mdu_data    MDU result offer; mdu_ready accepts it
//   chk1_add/chk2_add             hazard lookups; chkN_busy if queued
//   write_signal/add/data         register-file write port
//   stall_req                     pipeline must hold writeback
//   wb_drop                       WB request refused this cycle
//   pending                       number of queued entries
module reg_write_arbiter #(
  parameter int unsigned WORD_LEN     = 32,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wb_write,
  input  logic [4:0]               wb_add,
  input  logic [WORD_LEN-1:0]      wb_data,
  input  logic                     mdu_valid,
  input  logic [4:0]               mdu_add,
  input  logic [WORD_LEN-1:0]      mdu_data,
  output logic                     mdu_ready,
  input  logic [4:0]               chk1_add,
  input  logic [4:0]               chk2_add,
  output logic                     chk1_busy,
  output logic                     chk2_busy,
  output logic                     write_signal,
  output logic [4:0]               write_add,
  output logic [WORD_LEN-1:0]      write_data,
  output logic                     stall_req,
  output logic                     wb_drop,
  output logic [$clog2(DEPTH):0]   pending
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned PEND_W = PTR_W + 1;
  localparam int unsigned CNT_W  = $clog2(STARVE_LIMIT + 1);

  logic [4:0]          mem_add  [DEPTH];
  logic [WORD_LEN-1:0] mem_data [DEPTH];
  logic [DEPTH-1:0]    valid;
  logic [PTR_W-1:0]    rd_ptr;
  logic [PTR_W-1:0]    wr_ptr;
  logic [CNT_W-1:0]    starve_cnt;
  logic [CNT_W-1:0]    starve_nxt;
  logic                stall_nxt;
  logic                grant_fifo;
  logic                grant_wb;
  logic                push;
  logic                pop;
  logic                fifo_empty;

  // Handshake and grant decisions, all from registered state plus this cycle's requests.
  always_comb begin
    fifo_empty = (pending == PEND_W'(0));
    mdu_ready  = !rst && (pending < PEND_W'(DEPTH));
    push       = mdu_valid && mdu_ready && (mdu_add != 5'd0);
    grant_fifo = !rst && !fifo_empty && (stall_req || !wb_write);
    grant_wb   = !rst && wb_write && !stall_req;
    pop        = grant_fifo;
    wb_drop    = !rst && wb_write && stall_req;
  end

  // Register-file write port follows the granted source; idle drives zeros.
  always_comb begin
    write_signal = 1'b0;
    write_add    = 5'd0;
    write_data   = '0;
    if (grant_fifo) begin
      write_signal = 1'b1;
      write_add    = mem_add[rd_ptr];
      write_data   = mem_data[rd_ptr];
    end else if (grant_wb) begin
      write_signal = 1'b1;
      write_add    = wb_add;
      write_data   = wb_data;
    end
  end

  // Starvation counter and stall flag next values.
  always_comb begin
    starve_nxt = starve_cnt;
    stall_nxt  = stall_req;
    if (fifo_empty || grant_fifo) begin
      starve_nxt = CNT_W'(0);
    end else if (grant_wb && (starve_cnt < CNT_W'(STARVE_LIMIT))) begin
      starve_nxt = starve_cnt + CNT_W'(1);
    end
    // Last entry leaving with nothing arriving ends the drain.
    if (pop && (pending == PEND_W'(1)) && !push) begin
      stall_nxt = 1'b0;
    end else if (starve_nxt == CNT_W'(STARVE_LIMIT)) begin
      stall_nxt = 1'b1;
    end
  end

  // Hazard lookups see only entries already queued; register 0 is never busy.
  always_comb begin
    chk1_busy = 1'b0;
    chk2_busy = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && (mem_add[i] == chk1_add)) chk1_busy = 1'b1;
      if (valid[i] && (mem_add[i] == chk2_add)) chk2_busy = 1'b1;
    end
    if (rst || (chk1_add == 5'd0)) chk1_busy = 1'b0;
    if (rst || (chk2_add == 5'd0)) chk2_busy = 1'b0;
  end

  // Control state: pointers, occupancy, valid flags, starvation tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      pending    <= '0;
      valid      <= '0;
      starve_cnt <= '0;
      stall_req  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   pending <= pending + PEND_W'(1);
        2'b01:   pending <= pending - PEND_W'(1);
        default: pending <= pending;
      endcase
      // A full FIFO refuses pushes, so a set and clear never hit the same slot.
      if (pop)  valid[rd_ptr] <= 1'b0;
      if (push) valid[wr_ptr] <= 1'b1;
      starve_cnt <= starve_nxt;
      stall_req  <= stall_nxt;
    end
  end

  // Payload storage; qualified by valid, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_add[wr_ptr]  <= mdu_add;
      mem_data[wr_ptr] <= mdu_data;
    end
  end

endmodule
